// File: rtl/iterative_comparator_if.sv
// Request/result bundle for the iterative comparator. The request side
// carries valid/ready, both operands and the signedness flag. The result side
// carries valid/ready and the eq/lt flags.
interface iterative_comparator_if #(
    parameter int N = 32
);
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         is_signed;
    logic         o_valid;
    logic         o_ready;
    logic         eq;
    logic         lt;

    modport master (
        output i_valid, a, b, is_signed, o_ready,
        input  i_ready, o_valid, eq, lt
    );

    modport slave (
        input  i_valid, a, b, is_signed, o_ready,
        output i_ready, o_valid, eq, lt
    );
endinterface

// File: rtl/iterative_comparator.sv
// Sequential magnitude/equality comparator. It walks the operands CHUNK bits
// per cycle, starting from the MSB chunk, and stops at the first chunk that
// differs. For signed compares, the sign bit of the top chunk is flipped on
// both operands, so a plain unsigned compare orders two's-complement values.
// N must be a multiple of CHUNK.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | ready for a request; captures the operands on handshake
//   S_COMPARE | compares one chunk per cycle, from the MSB chunk down
//   S_DONE    | result valid; eq/lt held until o_ready
module iterative_comparator #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    iterative_comparator_if.slave bus
);
    localparam int NCHUNK = N / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            signed_q, signed_d;
    logic            eq_q, eq_d;
    logic            lt_q, lt_d;
    logic [CHUNK-1:0] ca, cb;

    // Select the current chunk, and apply the sign bias on the top chunk.
    always_comb begin
        ca = '0;
        cb = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                ca = a_q[i*CHUNK +: CHUNK];
                cb = b_q[i*CHUNK +: CHUNK];
            end
        end
        if (signed_q && (idx_q == IW'(NCHUNK - 1))) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
    end

    // Next-state logic for the FSM, the operand capture and the result flags.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    signed_d = bus.is_signed;
                    idx_d    = IW'(NCHUNK - 1);
                    state_d  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (ca != cb) begin
                    eq_d    = 1'b0;
                    lt_d    = (ca < cb);
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                if (bus.o_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset also clears the captured operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= IW'(NCHUNK - 1);
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    // Handshake flags are decoded from the registered state only.
    assign bus.i_ready = (state_q == S_IDLE);
    assign bus.o_valid = (state_q == S_DONE);
    assign bus.eq      = eq_q;
    assign bus.lt      = lt_q;
endmodule

// File: tb/tb_iterative_comparator.sv
// Scoreboard bench for iterative_comparator. The driver pushes the expected
// result, with its acceptance cycle, into a queue. The monitor pops one entry
// per result and checks eq, lt, latency, hold stability and i_ready.
module tb_iterative_comparator;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random stalls, 2: held low

    typedef struct {
        logic e;
        logic l;
        int   k;
        int   acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic in_res = 0;
    logic chk_iready = 0;

    iterative_comparator_if #(.N(32)) bus ();

    iterative_comparator #(.N(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      bus.o_ready = 1'b1;
        else if (ready_mode == 1) bus.o_ready = ($urandom_range(0, 2) != 0);
        else                      bus.o_ready = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_res     = 0;
            chk_iready = 0;
        end else begin
            if (chk_iready) begin
                chk("i_ready_after_handshake", 32'(bus.i_ready), 32'd1);
                chk_iready = 0;
            end
            if (bus.o_valid) begin
                if (!in_res) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_o_valid: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        cur    = q.pop_front();
                        in_res = 1;
                        chk("eq", 32'(bus.eq), 32'(cur.e));
                        chk("lt", 32'(bus.lt), 32'(cur.l));
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.k));
                    end
                end else begin
                    chk("eq_hold", 32'(bus.eq), 32'(cur.e));
                    chk("lt_hold", 32'(bus.lt), 32'(cur.l));
                end
                chk("i_ready_busy", 32'(bus.i_ready), 32'd0);
                if (bus.o_ready) begin
                    in_res     = 0;
                    chk_iready = 1;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic e, input logic l, input int k);
        int n = 0;
        exp_t x;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.is_signed = s;
        bus.i_valid = 1'b1;
        while (!bus.i_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.i_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got i_ready=0 expected 1 (cycle %0d)", cyc);
            bus.i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        x.e = e;
        x.l = l;
        x.k = k;
        x.acc = cyc;
        q.push_back(x);
        bus.i_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.is_signed = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || in_res) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || in_res) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic model_send(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic e, l;
        int k = 4;
        e = (a == b);
        l = s ? ($signed(a) < $signed(b)) : (a < b);
        for (int i = 3; i >= 0; i--) begin
            if (a[i*8 +: 8] != b[i*8 +: 8]) begin
                k = 4 - i;
                break;
            end
        end
        send(a, b, s, e, l, k);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        e;
        logic        l;
        int          k;
    } vec_t;

    vec_t vecs[10] = '{
        '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0, 4},
        '{32'h01000000, 32'h02000000, 1'b0, 1'b0, 1'b1, 1},
        '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1},
        '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1},
        '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1},
        '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1},
        '{32'h00001200, 32'h00001300, 1'b0, 1'b0, 1'b1, 3},
        '{32'hFFFFFF80, 32'hFFFFFF7F, 1'b1, 1'b0, 1'b0, 4},
        '{32'h7F000000, 32'hFF000000, 1'b1, 1'b0, 1'b0, 1},
        '{32'h7F000000, 32'hFF000000, 1'b0, 1'b0, 1'b1, 1}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int n;
        rst_n = 1'b1;
        bus.i_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.is_signed = 1'b0;
        bus.o_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_i_ready", 32'(bus.i_ready), 32'd1);
        chk("reset_o_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_eq", 32'(bus.eq), 32'd0);
        chk("reset_lt", 32'(bus.lt), 32'd0);
        #3 rst_n = 1'b1;

        // Directed vectors, downstream always ready.
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, vecs[i].l, vecs[i].k);
        end
        send(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4);
        drain();

        // Backpressure: hold o_ready low and wiggle the inputs while busy.
        ready_mode = 2;
        send(32'd5, 32'd7, 1'b0, 1'b0, 1'b1, 4);
        n = 0;
        while (!bus.o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_o_valid", 32'(bus.o_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.is_signed = 1'($urandom);
        end
        ready_mode = 0;
        send(32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 4);
        send(32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4);
        drain();

        // Asynchronous reset in the middle of a compare.
        send(32'd5, 32'd7, 1'b0, 1'b0, 1'b1, 4);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_o_valid", 32'(bus.o_valid), 32'd0);
        chk("abort_eq", 32'(bus.eq), 32'd0);
        chk("abort_lt", 32'(bus.lt), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_i_ready", 32'(bus.i_ready), 32'd1);
        send(32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 4);
        drain();

        // Model-checked mix with random stalls: random, equal, one-chunk-apart.
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            case (i % 3)
                0: rb = $urandom;
                1: rb = ra;
                default: begin
                    rb = ra;
                    rb[$urandom_range(0, 3)*8 +: 8] = 8'($urandom_range(1, 255)) ^ ra[7:0];
                end
            endcase
            model_send(ra, rb, 1'($urandom));
        end
        drain();
        ready_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
